// File: rtl/multiword_add_ctrl.sv
// ============================================================================
// Module   : multiword_add_ctrl (with helper cla)
// Purpose  : Multi-cycle wide add/subtract that reuses one WIDTH-bit adder slice
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]  = p[i] ^ carry;
            carry = g[i] | (p[i] & carry);
        end
        cout = carry;
    end
endmodule

module multiword_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] s,
    output logic                   cout,
    output logic                   ovf
);
    localparam int TOTAL = WIDTH * WORDS;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TOTAL-1:0]  a_q, a_d;
    logic [TOTAL-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [TOTAL-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  slice_a;
    logic [WIDTH-1:0]  slice_b;
    logic [WIDTH-1:0]  slice_s;
    logic              slice_c;

    assign slice_a = a_q[int'(k_q)*WIDTH +: WIDTH];
    assign slice_b = b_q[int'(k_q)*WIDTH +: WIDTH];

    cla #(.WIDTH(WIDTH)) u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        s_d       = s_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1, so the inversion and forced carry are
                    // folded in here and the datapath never needs op_sub again.
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub | cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(k_q)*WIDTH +: WIDTH] = slice_s;
                carry_d = slice_c;
                if (k_q == LAST) begin
                    k_d     = '0;
                    cout_d  = slice_c;
                    ovf_d   = (a_q[TOTAL-1] == b_q[TOTAL-1]) & (slice_s[WIDTH-1] != a_q[TOTAL-1]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

`default_nettype wire

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the slice width of the internal cla instance.
REQ-002 The block SHALL have parameter WORDS, default 4, giving the slices per operand; legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operation request.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have port a, input, WIDTH*WORDS, first operand.
REQ-008 The block SHALL have port b, input, WIDTH*WORDS, second operand.
REQ-009 The block SHALL have port cin, input, 1, carry-in for add; ignored for subtract.
REQ-010 The block SHALL have port op_sub, input, 1: 0 = a+b+cin, 1 = a-b.
REQ-011 The block SHALL have port out_valid, output, 1, result available.
REQ-012 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-013 The block SHALL have port s, output, WIDTH*WORDS, registered sum/difference.
REQ-014 The block SHALL have port cout, output, 1, carry out of the MSB slice; for subtract, 1 = no borrow.
REQ-015 The block SHALL have port ovf, output, 1, two's-complement signed overflow of the full-width result.

Function
REQ-016 The block SHALL instantiate exactly one cla #(WIDTH) and sequence it over WORDS cycles, LSB slice first.
REQ-017 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-019 Accept SHALL occur on an edge where in_valid & in_ready; that edge SHALL capture a, b, and op_sub, SHALL load the carry register with (op_sub ? 1 : cin), SHALL clear the slice index to 0, and SHALL move the FSM to RUN.
REQ-020 For subtract, b SHALL be captured bitwise inverted.
REQ-021 Changes to a, b, cin, op_sub or in_valid after accept SHALL have no effect until the next accept.
REQ-022 In RUN, each edge SHALL write slice k of the cla sum into s[k*WIDTH +: WIDTH], SHALL load carry with cla cout, and SHALL increment k.
REQ-023 On the edge that processes slice WORDS-1, the FSM SHALL go to DONE and SHALL register cout and ovf.
REQ-024 out_valid SHALL be 1 exactly in DONE; it SHALL first be high in the cycle after the WORDS-th RUN edge, i.e. WORDS edges after accept.
REQ-025 ovf SHALL equal (a_msb == b_eff_msb) & (s_msb != a_msb), where b_eff is the captured (possibly inverted) b.
REQ-026 In DONE, s, cout and ovf SHALL be held stable until an edge with out_ready = 1; that edge SHALL return the FSM to IDLE.
REQ-027 s, cout and ovf SHALL retain the last result in IDLE and SHALL be overwritten only during the next RUN.
REQ-028 When WORDS = 1, RUN SHALL last exactly one cycle.
REQ-029 Minimum spacing between consecutive accepts SHALL be WORDS+2 edges; no accept in DONE.

Reset
REQ-030 On an edge with reset = 1, the FSM SHALL go to IDLE, and k, carry, s, cout and ovf SHALL be cleared to 0, overriding any other event including mid-RUN and DONE.
REQ-031 In the cycle after reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-032 An in_valid coincident with reset SHALL NOT be accepted.

Verification (WIDTH=32, WORDS=4)
REQ-033 The bench SHALL check: a = all-ones, b = 0, cin = 1, add -> s = 0, cout = 1, ovf = 0; out_valid rises exactly 4 edges after accept.
REQ-034 The bench SHALL check the inter-slice carry: a = 0x...0000_FFFFFFFF, b = 1, cin = 0 -> s = 0x...0001_00000000, cout = 0.
REQ-035 The bench SHALL check subtract 5 - 7 -> s = 2^128-2, cout = 0, ovf = 0, and add 0x7FFF...F + 1 -> s = 0x8000...0, ovf = 1.
REQ-036 The bench SHALL hold out_ready = 0 for 10 cycles in DONE -> out_valid, s, cout and ovf stay stable and in_ready = 0; then raise out_ready -> IDLE and in_ready = 1 on the next cycle.
REQ-037 The bench SHALL assert reset while k = 2 in RUN -> next cycle IDLE, s = 0, out_valid = 0; a following op returns the correct result.
REQ-038 The bench SHALL run 1000 random ops (random op_sub, cin and backpressure, inputs toggled during RUN) against a 129-bit reference model with zero mismatches, and SHALL print the test and error counts.
